// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
// Module      : if_id_buffer
// Description : Fetch-to-decode stage buffer. Captures each fetched
//               (PC, instruction) pair in a 2-entry skid FIFO and presents
//               the oldest pair to decode through a valid/ready handshake.
//               Decode stalls propagate back to the PC register via InReady.
//               Flush discards all buffered entries on taken branches/jumps.
//
// Ports       : Clk         rising-edge clock
//               Reset       asynchronous active-low reset
//               PCIn        PC of the fetched instruction
//               InstrIn     instruction memory read data for PCIn
//               InValid     PCIn/InstrIn carry a valid fetch
//               InReady     buffer can accept a fetch (PC register hold)
//               Flush       synchronous kill of all buffered entries
//               OutPC       PC of the head entry
//               OutPCPlus4  OutPC + PC_INC
//               OutInstr    instruction of the head entry (NOP when empty)
//               OutFault    head entry was fetched out of range
//               OutValid    head entry is valid
//               OutReady    decode consumes the head entry this cycle
//
// Options     : IFID_RANGE_CHECK_EN - when defined, fetches at PCIn >=
//               IMEM_LIMIT are stored as NOP_INSTR with the fault bit set.
//               When undefined, the fault path is absent and OutFault = 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_buffer #(
`ifdef IFID_RANGE_CHECK_EN
    parameter logic [31:0] IMEM_LIMIT = 32'd36,
`endif
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
    parameter logic [31:0] PC_INC     = 32'd4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCIn,
    input  logic [31:0] InstrIn,
    input  logic        InValid,
    output logic        InReady,
    input  logic        Flush,
    output logic [31:0] OutPC,
    output logic [31:0] OutPCPlus4,
    output logic [31:0] OutInstr,
    output logic        OutFault,
    output logic        OutValid,
    input  logic        OutReady
);

    localparam logic [1:0] c_empty = 2'd0;
    localparam logic [1:0] c_full  = 2'd2;

    logic [31:0] r_pc    [2];
    logic [31:0] r_instr [2];
    logic        r_wrptr;
    logic        r_rdptr;
    logic [1:0]  r_count;

    logic        w_push;
    logic        w_pop;
    logic [31:0] w_instr_st;

`ifdef IFID_RANGE_CHECK_EN
    logic        r_fault [2];
    logic        w_fault_st;

    // Out-of-range fetches are neutralised to a NOP before storage so that
    // decode never acts on garbage read data; the PC is kept for reporting.
    assign w_fault_st = (PCIn >= IMEM_LIMIT);
    assign w_instr_st = w_fault_st ? NOP_INSTR : InstrIn;
`else
    assign w_instr_st = InstrIn;
`endif

    // InReady depends on state only, so upstream never sees a combinational
    // path from decode's OutReady or from Flush.
    assign InReady  = (r_count != c_full);
    assign OutValid = (r_count != c_empty);

    assign w_push = InValid && InReady;
    assign w_pop  = OutValid && OutReady;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_wrptr <= 1'b0;
            r_rdptr <= 1'b0;
            r_count <= c_empty;
            for (int i = 0; i < 2; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
`ifdef IFID_RANGE_CHECK_EN
                r_fault[i] <= 1'b0;
`endif
            end
        end else if (Flush) begin
            // A push in this cycle was handshaken upstream but is dropped;
            // entry contents are left as they are.
            r_wrptr <= 1'b0;
            r_rdptr <= 1'b0;
            r_count <= c_empty;
        end else begin
            if (w_push) begin
                r_pc[r_wrptr]    <= PCIn;
                r_instr[r_wrptr] <= w_instr_st;
`ifdef IFID_RANGE_CHECK_EN
                r_fault[r_wrptr] <= w_fault_st;
`endif
                r_wrptr          <= ~r_wrptr;
            end
            if (w_pop) begin
                r_rdptr <= ~r_rdptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head outputs are forced to neutral values while the buffer is empty so
    // that decode sees a NOP rather than stale entry data.
    assign OutPC      = OutValid ? r_pc[r_rdptr] : '0;
    assign OutPCPlus4 = OutValid ? (r_pc[r_rdptr] + PC_INC) : '0;
    assign OutInstr   = OutValid ? r_instr[r_rdptr] : NOP_INSTR;
`ifdef IFID_RANGE_CHECK_EN
    assign OutFault   = OutValid ? r_fault[r_rdptr] : 1'b0;
`else
    assign OutFault   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_buffer
// Description : Self-checking bench for if_id_buffer. Accepted beats are
//               pushed to a scoreboard queue and the head outputs are compared
//               against the queue front every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_buffer;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } beat_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rdy;
        logic        fl;
    } stim_t;

    logic        Clk;
    logic        Reset;
    logic [31:0] PCIn;
    logic [31:0] InstrIn;
    logic        InValid;
    logic        InReady;
    logic        Flush;
    logic [31:0] OutPC;
    logic [31:0] OutPCPlus4;
    logic [31:0] OutInstr;
    logic        OutFault;
    logic        OutValid;
    logic        OutReady;

    int    n_cmp  = 0;
    int    n_fail = 0;
    beat_t exp_q[$];

    if_id_buffer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .PCIn       (PCIn),
        .InstrIn    (InstrIn),
        .InValid    (InValid),
        .InReady    (InReady),
        .Flush      (Flush),
        .OutPC      (OutPC),
        .OutPCPlus4 (OutPCPlus4),
        .OutInstr   (OutInstr),
        .OutFault   (OutFault),
        .OutValid   (OutValid),
        .OutReady   (OutReady)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference for what a beat looks like once stored.
    function automatic beat_t make_beat(input logic [31:0] pc, input logic [31:0] instr);
        beat_t b;
        b.pc    = pc;
        b.instr = instr;
        b.fault = 1'b0;
`ifdef IFID_RANGE_CHECK_EN
        if (pc >= 32'd36) begin
            b.instr = 32'h0000_0000;
            b.fault = 1'b1;
        end
`endif
        return b;
    endfunction

    // Advance one clock and update the scoreboard from the bench's own model
    // of occupancy (not from DUT outputs).
    task automatic step();
        logic push, pop;
        push = InValid && (exp_q.size() != 2);
        pop  = (exp_q.size() != 0) && OutReady;
        @(posedge Clk);
        if (Flush) begin
            exp_q.delete();
        end else begin
            if (pop)  void'(exp_q.pop_front());
            if (push) exp_q.push_back(make_beat(PCIn, InstrIn));
        end
        #1;
    endtask

    task automatic drive(input stim_t s);
        InValid  = s.v;
        PCIn     = s.pc;
        InstrIn  = s.instr;
        OutReady = s.rdy;
        Flush    = s.fl;
    endtask

    task automatic test_reset();
        logic [31:0] pc;
        Reset = 1'b0; InValid = 1'b0; PCIn = '0; InstrIn = '0;
        Flush = 1'b0; OutReady = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        n_cmp++;
        if (OutValid !== 1'b0 || InReady !== 1'b1 || OutPC !== 32'h0 || OutInstr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_held: valid=%b inready=%b pc=%h instr=%h, need 0/1/00000000/00000000",
                     OutValid, InReady, OutPC, OutInstr);
        end
        Reset = 1'b1;
        exp_q.delete();
        @(posedge Clk); #1;
        n_cmp++;
        if (OutValid !== 1'b0 || InReady !== 1'b1 || OutPC !== 32'h0 || OutPCPlus4 !== 32'h0 ||
            OutInstr !== 32'h0 || OutFault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: valid=%b inready=%b pc=%h pc4=%h instr=%h fault=%b, need 0/1/0/0/0/0",
                     OutValid, InReady, OutPC, OutPCPlus4, OutInstr, OutFault);
        end
        // Asynchronous reset in the middle of operation.
        pc = 32'h0000_0010;
        InValid = 1'b1; PCIn = pc; InstrIn = 32'h1111_2222;
        step();
        InValid = 1'b0;
        n_cmp++;
        if (OutValid !== 1'b1 || OutPC !== pc) begin
            n_fail++;
            $display("FAIL async_pre: valid=%b pc=%h, need 1/%h", OutValid, OutPC, pc);
        end
        #2 Reset = 1'b0;
        #1;
        n_cmp++;
        if (OutValid !== 1'b0 || InReady !== 1'b1 || OutPC !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b inready=%b pc=%h, need 0/1/00000000",
                     OutValid, InReady, OutPC);
        end
        exp_q.delete();
        @(posedge Clk); #1;
        Reset = 1'b1;
    endtask

    task automatic run_rows_push_drain();
        stim_t tbl [4] = '{
            '{1'b1, 32'h0000_0000, 32'h2002_0005, 1'b1, 1'b0},
            '{1'b1, 32'h0000_0004, 32'h2003_0001, 1'b1, 1'b0},
            '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0},
            '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0}
        };
        logic ev, ef; logic [31:0] epc, epc4, ein;
        n_cmp++;
        if (OutValid !== 1'b0) begin
            n_fail++;
            $display("FAIL push_drain_pre: valid=%b, need 0", OutValid);
        end
        for (int i = 0; i < 4; i++) begin
            drive(tbl[i]);
            n_cmp++;
            if (InReady !== (exp_q.size() != 2)) begin
                n_fail++;
                $display("FAIL push_drain_inready[%0d]: got %b need %b", i, InReady, exp_q.size() != 2);
            end
            step();
            ev = (exp_q.size() != 0);
            epc = ev ? exp_q[0].pc : 32'h0; epc4 = ev ? exp_q[0].pc + 32'd4 : 32'h0;
            ein = ev ? exp_q[0].instr : 32'h0; ef = ev ? exp_q[0].fault : 1'b0;
            n_cmp++;
            if (OutValid !== ev || OutPC !== epc || OutPCPlus4 !== epc4 || OutInstr !== ein || OutFault !== ef) begin
                n_fail++;
                $display("FAIL push_drain_head[%0d]: got v=%b pc=%h pc4=%h instr=%h f=%b need v=%b pc=%h pc4=%h instr=%h f=%b",
                         i, OutValid, OutPC, OutPCPlus4, OutInstr, OutFault, ev, epc, epc4, ein, ef);
            end
            n_cmp++;
            if (exp_q.size() > 1) begin
                n_fail++;
                $display("FAIL push_drain_depth[%0d]: got %0d need <=1", i, exp_q.size());
            end
        end
    endtask

    task automatic test_push_drain();
        run_rows_push_drain();
    endtask

    task automatic test_backpressure();
        stim_t tbl [7] = '{
            '{1'b1, 32'h0000_0008, 32'hAAAA_0008, 1'b0, 1'b0},
            '{1'b1, 32'h0000_000C, 32'hAAAA_000C, 1'b0, 1'b0},
            '{1'b1, 32'h0000_0010, 32'hAAAA_0010, 1'b0, 1'b0},
            '{1'b1, 32'h0000_0010, 32'hAAAA_0010, 1'b1, 1'b0},
            '{1'b1, 32'h0000_0010, 32'hAAAA_0010, 1'b1, 1'b0},
            '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0},
            '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0}
        };
        logic ev, ef; logic [31:0] epc, epc4, ein;
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i]);
            n_cmp++;
            if (InReady !== (exp_q.size() != 2)) begin
                n_fail++;
                $display("FAIL backpressure_inready[%0d]: got %b need %b", i, InReady, exp_q.size() != 2);
            end
            step();
            ev = (exp_q.size() != 0);
            epc = ev ? exp_q[0].pc : 32'h0; epc4 = ev ? exp_q[0].pc + 32'd4 : 32'h0;
            ein = ev ? exp_q[0].instr : 32'h0; ef = ev ? exp_q[0].fault : 1'b0;
            n_cmp++;
            if (OutValid !== ev || OutPC !== epc || OutPCPlus4 !== epc4 || OutInstr !== ein || OutFault !== ef) begin
                n_fail++;
                $display("FAIL backpressure_head[%0d]: got v=%b pc=%h pc4=%h instr=%h f=%b need v=%b pc=%h pc4=%h instr=%h f=%b",
                         i, OutValid, OutPC, OutPCPlus4, OutInstr, OutFault, ev, epc, epc4, ein, ef);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t tbl [5] = '{
            '{1'b1, 32'h0000_0100, 32'hB000_0100, 1'b1, 1'b0},
            '{1'b1, 32'h0000_0104, 32'hB000_0104, 1'b1, 1'b0},
            '{1'b1, 32'h0000_0108, 32'hB000_0108, 1'b1, 1'b0},
            '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0},
            '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0}
        };
        logic ev, ef; logic [31:0] epc, epc4, ein;
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i]);
            n_cmp++;
            if (InReady !== 1'b1) begin
                n_fail++;
                $display("FAIL back_to_back_inready[%0d]: got %b need 1", i, InReady);
            end
            step();
            ev = (exp_q.size() != 0);
            epc = ev ? exp_q[0].pc : 32'h0; epc4 = ev ? exp_q[0].pc + 32'd4 : 32'h0;
            ein = ev ? exp_q[0].instr : 32'h0; ef = ev ? exp_q[0].fault : 1'b0;
            n_cmp++;
            if (OutValid !== ev || OutPC !== epc || OutPCPlus4 !== epc4 || OutInstr !== ein || OutFault !== ef) begin
                n_fail++;
                $display("FAIL back_to_back_head[%0d]: got v=%b pc=%h pc4=%h instr=%h f=%b need v=%b pc=%h pc4=%h instr=%h f=%b",
                         i, OutValid, OutPC, OutPCPlus4, OutInstr, OutFault, ev, epc, epc4, ein, ef);
            end
        end
    endtask

    task automatic test_flush();
        stim_t tbl [8] = '{
            '{1'b1, 32'h0000_0200, 32'hC000_0200, 1'b0, 1'b0},
            '{1'b1, 32'h0000_0204, 32'hC000_0204, 1'b0, 1'b0},
            '{1'b1, 32'h0000_0240, 32'hC000_0240, 1'b0, 1'b1},
            '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0},
            '{1'b1, 32'h0000_0248, 32'hC000_0248, 1'b0, 1'b0},
            '{1'b1, 32'h0000_024C, 32'hC000_024C, 1'b1, 1'b1},
            '{1'b1, 32'h0000_0250, 32'hC000_0250, 1'b1, 1'b0},
            '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0}
        };
        logic ev, ef; logic [31:0] epc, epc4, ein;
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i]);
            n_cmp++;
            if (InReady !== (exp_q.size() != 2)) begin
                n_fail++;
                $display("FAIL flush_inready[%0d]: got %b need %b", i, InReady, exp_q.size() != 2);
            end
            step();
            ev = (exp_q.size() != 0);
            epc = ev ? exp_q[0].pc : 32'h0; epc4 = ev ? exp_q[0].pc + 32'd4 : 32'h0;
            ein = ev ? exp_q[0].instr : 32'h0; ef = ev ? exp_q[0].fault : 1'b0;
            n_cmp++;
            if (OutValid !== ev || OutPC !== epc || OutPCPlus4 !== epc4 || OutInstr !== ein || OutFault !== ef) begin
                n_fail++;
                $display("FAIL flush_head[%0d]: got v=%b pc=%h pc4=%h instr=%h f=%b need v=%b pc=%h pc4=%h instr=%h f=%b",
                         i, OutValid, OutPC, OutPCPlus4, OutInstr, OutFault, ev, epc, epc4, ein, ef);
            end
        end
        Flush = 1'b0;
    endtask

    task automatic test_range();
        stim_t tbl [5] = '{
            '{1'b1, 32'h0000_0024, 32'h8C08_0000, 1'b1, 1'b0},
            '{1'b1, 32'h0000_0020, 32'h8C09_0004, 1'b1, 1'b0},
            '{1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 1'b1, 1'b0},
            '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0},
            '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0}
        };
        logic ev, ef; logic [31:0] epc, epc4, ein;
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i]);
            step();
            ev = (exp_q.size() != 0);
            epc = ev ? exp_q[0].pc : 32'h0; epc4 = ev ? exp_q[0].pc + 32'd4 : 32'h0;
            ein = ev ? exp_q[0].instr : 32'h0; ef = ev ? exp_q[0].fault : 1'b0;
            n_cmp++;
            if (OutValid !== ev || OutPC !== epc || OutPCPlus4 !== epc4 || OutInstr !== ein || OutFault !== ef) begin
                n_fail++;
                $display("FAIL range_head[%0d]: got v=%b pc=%h pc4=%h instr=%h f=%b need v=%b pc=%h pc4=%h instr=%h f=%b",
                         i, OutValid, OutPC, OutPCPlus4, OutInstr, OutFault, ev, epc, epc4, ein, ef);
            end
        end
    endtask

    initial begin
        test_reset();
        test_push_drain();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
Fetch-to-decode stage buffer that sits directly downstream of the PC register and instruction memory. It captures each fetched (PC, instruction) pair in a 2-entry skid FIFO. It presents the oldest pair to the decode stage with a valid/ready handshake, so decode stalls back-pressure the PC. A flush input kills in-flight fetches on taken branches and jumps.

Parameters:
NOP_INSTR, 32'h00000000, instruction word driven when the stage is empty
PC_INC, 4, increment added to the head PC to form OutPCPlus4
IMEM_LIMIT, 36, first out-of-range byte address; used only with the optional feature

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset (0 = reset asserted)
PCIn  input  32  PC of the fetched instruction (from the PC register output)
InstrIn  input  32  instruction memory read data for PCIn
InValid  input  1  PCIn/InstrIn hold a valid fetch
InReady  output  1  buffer can accept a fetch this cycle; drives the PC register hold/stall
Flush  input  1  synchronous kill of all buffered entries
OutPC  output  32  PC of the head entry
OutPCPlus4  output  32  OutPC + PC_INC
OutInstr  output  32  instruction of the head entry
OutFault  output  1  head entry was fetched out of range (optional feature only)
OutValid  output  1  head entry is valid
OutReady  input  1  decode consumes the head entry this cycle

Behaviour:
- Storage: 2 entries. Each entry holds {pc[31:0], instr[31:0], fault}. State is a 1-bit write pointer, a 1-bit read pointer and a 2-bit count (0..2). Pointers wrap 1->0.
- Reset (Reset=0, asynchronous): count=0, both pointers=0, all entry fields=0. Outputs during and after reset: OutValid=0, InReady=1, OutPC=0, OutPCPlus4=0, OutInstr=NOP_INSTR, OutFault=0.
- InReady = (count != 2). It is decoded from state flops only, with no combinational path from OutReady or Flush.
- OutValid = (count != 0).
- Push = InValid && InReady. Pop = OutValid && OutReady. Both are evaluated at the rising edge.
- Push writes the entry at wrptr, then wrptr is incremented. Pop increments rdptr.
- Count update:
  - push only: count+1
  - pop only: count-1
  - push and pop together: count unchanged
  - at count=2, push is impossible; at count=0, pop is impossible.
- Latency: a beat pushed at edge N appears on the outputs after edge N (one cycle). There is no fall-through path.
- Ordering: strict FIFO.
- Head outputs:
  - when OutValid=1: OutPC, OutInstr and OutFault come from entry[rdptr], and OutPCPlus4 = OutPC + PC_INC, truncated to 32 bits (0xFFFFFFFC -> 0x00000000).
  - when OutValid=0: OutPC=0, OutPCPlus4=0, OutInstr=NOP_INSTR, OutFault=0.
- Flush has highest priority at the edge:
  - count, wrptr and rdptr go to 0.
  - A push in the same cycle is handshaken (upstream sees it accepted) but discarded.
  - A pop in the same cycle is a no-op.
  - Entry data is not cleared.
- Reset asserted mid-operation clears state immediately, regardless of Clk.
- Entry fields are written only on push; entries are never modified in place.

Optional Feature:
IFID_RANGE_CHECK_EN
- Defined: a pushed beat with PCIn >= IMEM_LIMIT is stored with instr=NOP_INSTR and fault=1. PCIn is stored unchanged. In-range beats are stored with fault=0.
- Not defined: beats are stored unchanged, the fault bit and its logic are removed, and OutFault is tied to 0. IMEM_LIMIT is unused.

Test Plan:
- Reset: Reset=0 for 2 cycles, then release -> OutValid=0, InReady=1, OutInstr=0x00000000, OutPC=0.
- Push and drain: OutReady=1, push PC 0x0/0x20020005 then PC 0x4/0x20030001 back-to-back -> OutValid rises one cycle after the first push. Outputs are PC 0x0, PCPlus4 0x4, then PC 0x4, PCPlus4 0x8. count never exceeds 1.
- Back-pressure: OutReady=0, push 3 beats with PC 0x8/0xC/0x10 -> InReady=0 after the 2nd push and the 3rd is held upstream. Raise OutReady -> outputs 0x8 then 0xC, then the 0x10 beat is accepted and appears.
- Simultaneous push and pop at count=1 -> count stays 1 and order is preserved across the pointer wrap.
- Flush: count=2, assert Flush with InValid=1 -> next cycle OutValid=0 and InReady=1. The flush-cycle beat never appears on the outputs.
- With IFID_RANGE_CHECK_EN: push PC 0x24 (36)/0x8C080000 -> OutPC=0x24, OutInstr=0x00000000, OutFault=1. Push PC 0x20 -> OutFault=0 and the instruction passes unchanged.
